conv_window_reader: RTL and testbench
=====================================

Name: conv_window_reader

Overview:
- Downstream consumer of the shared int4 dual-port feature-map RAM.
- After a start pulse, walks every valid KxK convolution window position (stride 1, no padding) of an IMG_H x IMG_W map held in RAM.
- Issues single-pixel reads on one RAM port, assembles each window into a packed vector and hands it to the conv MAC stage over a valid/ready handshake.
- Pulses done after the last window is accepted.

Parameters:
- WIDTH, 4, pixel width in bits; matches RAM word width.
- ADDR_BIT, 10, RAM address width.
- IMG_W, 28, feature-map width in pixels.
- IMG_H, 28, feature-map height in pixels.
- K, 3, window edge; window holds K*K pixels.
- BASE_ADDR, 0, RAM address of pixel (0,0); map stored row-major.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a frame scan when idle.
- busy  out  1  high from the cycle after start is accepted until done.
- ram_en  out  1  RAM port enable (read strobe).
- ram_we  out  1  RAM write enable; constant 0.
- ram_addr  out  ADDR_BIT  RAM read address.
- ram_dout  in  WIDTH  RAM read data; valid the cycle after the read is issued.
- win_data  out  K*K*WIDTH  packed window; pixel (r+i, c+j) at bits [WIDTH*(i*K+j) +: WIDTH].
- win_row  out  ADDR_BIT  output row r of the current window.
- win_col  out  ADDR_BIT  output column c of the current window.
- win_valid  out  1  window data valid.
- win_ready  in  1  consumer accepts when win_valid && win_ready.
- done  out  1  one-cycle pulse after the last window transfer.

Behaviour:
- Reset values: busy, ram_en, ram_we, win_valid, done = 0; ram_addr, win_data, win_row, win_col = 0; FSM = IDLE; counters cleared.
- Reset may assert in any state. The FSM returns to IDLE at once and any partial window is discarded. No done pulse is generated.
- RAM timing: a read issued in cycle n (ram_en=1, ram_addr valid) is captured from ram_dout at the end of cycle n+1.
- IDLE: ram_en=0. A start pulse moves the FSM to FETCH with r=c=0 and tap index t=0.
- FETCH, K*K cycles:
  - ram_en=1 and ram_addr = BASE_ADDR + (r+i)*IMG_W + (c+j), with i=t/K and j=t%K. i and j are tracked as counters; no divider.
  - Data for tap t-1 is captured each cycle.
  - After tap K*K-1 is issued, the FSM goes to DRAIN.
- DRAIN, 1 cycle: ram_en=0; captures the last tap, then moves to OUT.
- OUT:
  - win_valid=1. win_data, win_row and win_col stay stable until accepted.
  - On accept, c increments. If c = IMG_W-K, c wraps to 0 and r increments.
  - If the accepted window was r=IMG_H-K, c=IMG_W-K, the FSM goes to FIN. Otherwise it returns to FETCH with t=0.
- FIN: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Latency: start in cycle 0 gives the first win_valid in cycle K*K+2 (cycle 11 for K=3). With ready held high, windows repeat every K*K+2 cycles.
- Total windows per frame = (IMG_H-K+1)*(IMG_W-K+1); 676 for the defaults.
- start is ignored whenever the FSM is not IDLE, including the FIN cycle.
- Address arithmetic uses full ADDR_BIT width. The parameter check requires BASE_ADDR + IMG_H*IMG_W <= 2^ADDR_BIT; violation is a $error at elaboration.
- win_valid never drops without an accept. Backpressure of any length is tolerated with no RAM activity (ram_en=0) while in OUT.

Test Plan:
- Basic frame: IMG_W=IMG_H=4, K=3, RAM[a]=a mod 16, start -> 4 windows.
  - First (0,0): pixels 0,1,2,4,5,6,8,9,10; win_data=0xA98654210 (tap 0 in LSBs).
  - Last (1,1): pixels 5,6,7,9,10,11,13,14,15.
  - done one cycle after the 4th accept.
- Latency: win_ready tied 1, start at cycle 0 -> win_valid at cycles 11, 22, 33, 44; ram_addr sequence for the first window is 0,1,2,4,5,6,8,9,10.
- Backpressure: hold win_ready=0 for 20 cycles on window (0,1) -> win_data/win_row/win_col stable, ram_en=0 throughout; release -> next window (1,0) follows in 11 cycles.
- Start while busy: pulse start mid-frame and in the FIN cycle -> no restart, exactly 4 windows, one done.
- Reset mid-operation: assert rst during FETCH of window 2 -> all outputs 0 immediately; new start -> full 4-window frame from (0,0) with correct data.
- Default parameters, BASE_ADDR=100: full 28x28 frame -> 676 windows; last window's addresses end at 100+783; single done.

Source files
------------

// File: rtl/conv_window_reader.sv
// conv_window_reader
//
// Purpose: scans every KxK convolution window (stride 1, no padding) of an
// IMG_H x IMG_W int-WIDTH feature map that sits row-major in a shared
// dual-port RAM starting at BASE_ADDR. Each window is fetched one pixel per
// cycle over a single RAM port, packed into win_data and offered to the MAC
// stage over a valid/ready handshake. done pulses once after the final window
// has been accepted.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start               one-cycle pulse; only honoured while idle
//   busy                high while a frame scan is in progress
//   ram_en/ram_we       RAM read strobe / write enable (write is always 0)
//   ram_addr            RAM read address (0 whenever no read is issued)
//   ram_dout            RAM read data, one cycle after the read
//   win_data            packed window, tap (i,j) at [WIDTH*(i*K+j) +: WIDTH]
//   win_row/win_col     top-left output coordinate of the current window
//   win_valid/win_ready window handshake
//   done                one-cycle pulse after the last window transfer
module conv_window_reader #(
  parameter int WIDTH     = 4,
  parameter int ADDR_BIT  = 10,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int K         = 3,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_BIT-1:0]   ram_addr,
  input  logic [WIDTH-1:0]      ram_dout,
  output logic [K*K*WIDTH-1:0]  win_data,
  output logic [ADDR_BIT-1:0]   win_row,
  output logic [ADDR_BIT-1:0]   win_col,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  done
);

  localparam int TW = (K > 1) ? $clog2(K) : 1;
  localparam int WW = K * K * WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [ADDR_BIT-1:0] LAST_R  = ADDR_BIT'(IMG_H - K);
  localparam logic [ADDR_BIT-1:0] LAST_C  = ADDR_BIT'(IMG_W - K);
  localparam logic [TW-1:0]       TAP_MAX = TW'(K - 1);

  // The whole map must fit in the address space, and the window must be at
  // least 2x2 so the capture shift register has a real tail to shift.
  if ((longint'(BASE_ADDR) + longint'(IMG_H) * longint'(IMG_W)) > (longint'(1) << ADDR_BIT)) begin : g_addr_check
    $error("conv_window_reader: BASE_ADDR + IMG_H*IMG_W exceeds 2**ADDR_BIT");
  end
  if (K < 2 || K > IMG_W || K > IMG_H) begin : g_k_check
    $error("conv_window_reader: K must be >= 2 and fit inside the map");
  end

  logic [2:0]          state_q, state_d;
  logic [ADDR_BIT-1:0] r_q, r_d;
  logic [ADDR_BIT-1:0] c_q, c_d;
  logic [TW-1:0]       i_q, i_d;
  logic [TW-1:0]       j_q, j_d;
  logic                rd_pend_q, rd_pend_d;
  logic [WW-1:0]       win_data_q, win_data_d;
  logic [ADDR_BIT-1:0] fetch_addr;

  // Tap address for the pixel currently being fetched. i/j are the tap row
  // and column inside the window, stepped as counters so no divider is needed.
  always_comb begin
    fetch_addr = ADDR_BIT'(BASE_ADDR)
               + (r_q + ADDR_BIT'(i_q)) * ADDR_BIT'(IMG_W)
               + c_q + ADDR_BIT'(j_q);
  end

  // Next-state logic. Read data arrives one cycle after the strobe, so a
  // pending flag follows ram_en and each returning pixel is shifted in from
  // the top; after K*K shifts tap 0 has reached the least significant slot.
  // Captures only happen in FETCH and DRAIN, so win_data is frozen in OUT.
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    c_d        = c_q;
    i_d        = i_q;
    j_d        = j_q;
    rd_pend_d  = (state_q == S_FETCH);
    win_data_d = win_data_q;
    if (rd_pend_q) begin
      win_data_d = {ram_dout, win_data_q[WW-1:WIDTH]};
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          r_d     = '0;
          c_d     = '0;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_FETCH: begin
        if (j_q == TAP_MAX) begin
          j_d = '0;
          if (i_q == TAP_MAX) begin
            i_d     = '0;
            state_d = S_DRAIN;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        if (win_ready) begin
          if (r_q == LAST_R && c_q == LAST_C) begin
            state_d = S_FIN;
          end else begin
            state_d = S_FETCH;
            if (c_q == LAST_C) begin
              c_d = '0;
              r_d = r_q + 1'b1;
            end else begin
              c_d = c_q + 1'b1;
            end
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      c_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      rd_pend_q  <= 1'b0;
      win_data_q <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rd_pend_q  <= rd_pend_d;
      win_data_q <= win_data_d;
    end
  end

  // Outputs are pure decodes of the state; the address is gated so the bus
  // idles at zero instead of showing BASE_ADDR when no read is issued.
  always_comb begin
    busy      = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_OUT);
    ram_en    = (state_q == S_FETCH);
    ram_we    = 1'b0;
    ram_addr  = ram_en ? fetch_addr : '0;
    win_valid = (state_q == S_OUT);
    done      = (state_q == S_FIN);
    win_data  = win_data_q;
    win_row   = r_q;
    win_col   = c_q;
  end

endmodule

// File: tb/tb_conv_window_reader.sv
// tb_conv_window_reader
//
// Purpose: drives two conv_window_reader instances against behavioural RAM
// models. Instance A scans a 4x4 map (K=3, four windows) for the detailed
// scenarios; instance B uses the default 28x28 geometry at BASE_ADDR=100.
// Expected windows come from a direct row-major lookup into the RAM image.
module tb_conv_window_reader;

  localparam int WIDTH    = 4;
  localparam int ADDR_BIT = 10;
  localparam int K        = 3;
  localparam int WW       = K * K * WIDTH;
  localparam int AW       = 4;
  localparam int AH       = 4;
  localparam int ABASE    = 0;
  localparam int BW       = 28;
  localparam int BH       = 28;
  localparam int BBASE    = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                start_a, busy_a, ram_en_a, ram_we_a, win_valid_a, win_ready_a, done_a;
  logic [ADDR_BIT-1:0] ram_addr_a, win_row_a, win_col_a;
  logic [WIDTH-1:0]    ram_dout_a;
  logic [WW-1:0]       win_data_a;
  logic [WIDTH-1:0]    mem_a [0:1023];

  logic                start_b, busy_b, ram_en_b, ram_we_b, win_valid_b, win_ready_b, done_b;
  logic [ADDR_BIT-1:0] ram_addr_b, win_row_b, win_col_b;
  logic [WIDTH-1:0]    ram_dout_b;
  logic [WW-1:0]       win_data_b;
  logic [WIDTH-1:0]    mem_b [0:1023];

  int vectors = 0;
  int miscompares = 0;

  conv_window_reader #(.WIDTH(WIDTH), .ADDR_BIT(ADDR_BIT), .IMG_W(AW), .IMG_H(AH),
                       .K(K), .BASE_ADDR(ABASE)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a),
    .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_dout(ram_dout_a),
    .win_data(win_data_a), .win_row(win_row_a), .win_col(win_col_a),
    .win_valid(win_valid_a), .win_ready(win_ready_a), .done(done_a)
  );

  conv_window_reader #(.WIDTH(WIDTH), .ADDR_BIT(ADDR_BIT), .IMG_W(BW), .IMG_H(BH),
                       .K(K), .BASE_ADDR(BBASE)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
    .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_dout(ram_dout_b),
    .win_data(win_data_b), .win_row(win_row_b), .win_col(win_col_b),
    .win_valid(win_valid_b), .win_ready(win_ready_b), .done(done_b)
  );

  // Synchronous-read RAM models: data for a read appears the following cycle.
  always @(posedge clk) begin
    if (ram_en_a) ram_dout_a <= mem_a[ram_addr_a];
    if (ram_en_b) ram_dout_b <= mem_b[ram_addr_b];
  end

  // Reference window: pixel (r+i, c+j) read straight out of the row-major image.
  function automatic logic [WW-1:0] model_win(input logic [WIDTH-1:0] m [0:1023],
                                              input int base, input int w,
                                              input int r, input int c);
    logic [WW-1:0] v;
    v = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        v[WIDTH*(i*K+j) +: WIDTH] = m[base + (r+i)*w + c + j];
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    win_ready_a = 1'b0; win_ready_b = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy_a, ram_en_a, ram_we_a, win_valid_a, done_a} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl_a: got %b want 00000", {busy_a, ram_en_a, ram_we_a, win_valid_a, done_a});
    end
    vectors++;
    if ({ram_addr_a, win_row_a, win_col_a} !== 30'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_addr_a: got addr %0d row %0d col %0d want 0", ram_addr_a, win_row_a, win_col_a);
    end
    vectors++;
    if (win_data_a !== 36'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_data_a: got %h want 0", win_data_a);
    end
    vectors++;
    if ({busy_b, ram_en_b, ram_we_b, win_valid_b, done_b, ram_addr_b} !== 15'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_b: got ctrl %b addr %0d want 0", {busy_b, ram_en_b, ram_we_b, win_valid_b, done_b}, ram_addr_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int cyc, nwin, ndone, done_cyc;
    int valid_cyc[4];
    int addr_seq[$];
    int exp_addr[9];
    logic [WW-1:0] exp_d;
    exp_addr = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    for (int a = 0; a < 1024; a++) mem_a[a] = 4'(a % 16);
    for (int k = 0; k < 4; k++) valid_cyc[k] = -1;
    win_ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1; nwin = 0; ndone = 0; done_cyc = -1;
    while (cyc < 80) begin
      vectors++;
      if (ram_we_a !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL ram_we: got %b want 0 at cycle %0d", ram_we_a, cyc);
      end
      if (ram_en_a && nwin == 0) addr_seq.push_back(int'(ram_addr_a));
      if (win_valid_a) begin
        if (nwin < 4) begin
          valid_cyc[nwin] = cyc;
          exp_d = model_win(mem_a, ABASE, AW, nwin / 2, nwin % 2);
          vectors++;
          if (win_data_a !== exp_d || win_row_a !== 10'(nwin / 2) || win_col_a !== 10'(nwin % 2)) begin
            miscompares++;
            $display("[TB] FAIL basic_win%0d: got %h (%0d,%0d) want %h (%0d,%0d)",
                     nwin, win_data_a, win_row_a, win_col_a, exp_d, nwin / 2, nwin % 2);
          end
          if (nwin == 0) begin
            vectors++;
            if (win_data_a !== 36'hA98654210) begin
              miscompares++;
              $display("[TB] FAIL first_window: got %h want a98654210", win_data_a);
            end
          end
          if (nwin == 3) begin
            vectors++;
            if (win_data_a !== 36'hFEDBA9765) begin
              miscompares++;
              $display("[TB] FAIL last_window: got %h want fedba9765", win_data_a);
            end
          end
        end
        nwin++;
      end
      if (done_a) begin
        ndone++;
        done_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (valid_cyc[k] !== 11 * (k + 1)) begin
        miscompares++;
        $display("[TB] FAIL latency_win%0d: got cycle %0d want %0d", k, valid_cyc[k], 11 * (k + 1));
      end
    end
    vectors++;
    if (nwin !== 4 || ndone !== 1 || done_cyc !== 45) begin
      miscompares++;
      $display("[TB] FAIL basic_count: got %0d windows %0d done at %0d want 4 windows 1 done at 45", nwin, ndone, done_cyc);
    end
    vectors++;
    if (addr_seq.size() !== 9) begin
      miscompares++;
      $display("[TB] FAIL addr_count: got %0d reads want 9", addr_seq.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        vectors++;
        if (addr_seq[k] !== exp_addr[k]) begin
          miscompares++;
          $display("[TB] FAIL addr_seq%0d: got %0d want %0d", k, addr_seq[k], exp_addr[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc, nwin, hold, acc_cyc;
    bit fresh, acc;
    logic [WW-1:0] exp_d, snap_d;
    logic [ADDR_BIT-1:0] snap_r, snap_c;
    snap_d = '0; snap_r = '0; snap_c = '0;
    for (int a = 0; a < 1024; a++) mem_a[a] = 4'($urandom);
    win_ready_a = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1; nwin = 0; hold = 0; acc_cyc = -100; fresh = 1'b1;
    while (nwin < 4 && cyc < 600) begin
      acc = 1'b0;
      if (win_valid_a) begin
        if (fresh) begin
          exp_d = model_win(mem_a, ABASE, AW, nwin / 2, nwin % 2);
          vectors++;
          if (win_data_a !== exp_d || win_row_a !== 10'(nwin / 2) || win_col_a !== 10'(nwin % 2)) begin
            miscompares++;
            $display("[TB] FAIL bp_win%0d: got %h (%0d,%0d) want %h (%0d,%0d)",
                     nwin, win_data_a, win_row_a, win_col_a, exp_d, nwin / 2, nwin % 2);
          end
          if (nwin == 2) begin
            vectors++;
            if (cyc - acc_cyc !== 11) begin
              miscompares++;
              $display("[TB] FAIL bp_release_latency: got %0d cycles want 11", cyc - acc_cyc);
            end
          end
          snap_d = win_data_a; snap_r = win_row_a; snap_c = win_col_a;
          fresh = 1'b0;
        end else begin
          vectors++;
          if (win_data_a !== snap_d || win_row_a !== snap_r || win_col_a !== snap_c) begin
            miscompares++;
            $display("[TB] FAIL bp_stable: got %h (%0d,%0d) want %h (%0d,%0d)",
                     win_data_a, win_row_a, win_col_a, snap_d, snap_r, snap_c);
          end
        end
        vectors++;
        if (ram_en_a !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL bp_ram_idle: got ram_en %b want 0", ram_en_a);
        end
        if (nwin == 1) begin
          win_ready_a = (hold >= 20);
          hold++;
        end else begin
          win_ready_a = 1'($urandom);
        end
        acc = win_ready_a;
      end else begin
        win_ready_a = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        if (nwin == 1) acc_cyc = cyc - 1;
        nwin++;
        fresh = 1'b1;
      end
    end
    vectors++;
    if (nwin !== 4 || done_a !== 1'b1 || busy_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_finish: got %0d windows done %b busy %b want 4 1 0", nwin, done_a, busy_a);
    end
    win_ready_a = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int cyc, nwin, ndone;
    win_ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1; nwin = 0; ndone = 0;
    while (cyc < 100) begin
      if (win_valid_a) begin
        vectors++;
        if (win_row_a !== 10'(nwin / 2) || win_col_a !== 10'(nwin % 2)) begin
          miscompares++;
          $display("[TB] FAIL busy_order%0d: got (%0d,%0d) want (%0d,%0d)", nwin, win_row_a, win_col_a, nwin / 2, nwin % 2);
        end
        nwin++;
      end
      if (done_a) ndone++;
      start_a = (cyc == 5 || cyc == 17 || cyc == 22 || cyc == 30 || done_a);
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    vectors++;
    if (nwin !== 4 || ndone !== 1 || busy_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_ignored: got %0d windows %0d done busy %b want 4 1 0", nwin, ndone, busy_a);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, nwin, ndone;
    logic [WW-1:0] exp_d;
    for (int a = 0; a < 1024; a++) mem_a[a] = 4'($urandom);
    win_ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (25) @(negedge clk);
    vectors++;
    if (ram_en_a !== 1'b1 || win_row_a !== 10'd1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_fetching: got ram_en %b row %0d want 1 1", ram_en_a, win_row_a);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy_a, ram_en_a, win_valid_a, done_a, ram_addr_a, win_row_a, win_col_a} !== 34'h0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_outputs: got ctrl %b addr %0d row %0d col %0d want 0",
               {busy_a, ram_en_a, win_valid_a, done_a}, ram_addr_a, win_row_a, win_col_a);
    end
    vectors++;
    if (win_data_a !== 36'h0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_data: got %h want 0", win_data_a);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_quiet: got done %b busy %b want 0 0", done_a, busy_a);
    end
    for (int a = 0; a < 1024; a++) mem_a[a] = 4'($urandom);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1; nwin = 0; ndone = 0;
    while (cyc < 60) begin
      if (win_valid_a) begin
        exp_d = model_win(mem_a, ABASE, AW, nwin / 2, nwin % 2);
        vectors++;
        if (win_data_a !== exp_d || win_row_a !== 10'(nwin / 2) || win_col_a !== 10'(nwin % 2)) begin
          miscompares++;
          $display("[TB] FAIL rstmid_win%0d: got %h (%0d,%0d) want %h (%0d,%0d)",
                   nwin, win_data_a, win_row_a, win_col_a, exp_d, nwin / 2, nwin % 2);
        end
        nwin++;
      end
      if (done_a) ndone++;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (nwin !== 4 || ndone !== 1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_frame: got %0d windows %0d done want 4 1", nwin, ndone);
    end
  endtask

  task automatic test_full_frame();
    int cyc, nwin, ndone, last_addr, min_addr, er, ec;
    bit acc;
    logic [WW-1:0] exp_d;
    for (int a = 0; a < 1024; a++) mem_b[a] = 4'($urandom);
    win_ready_b = 1'b0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 1; nwin = 0; ndone = 0; last_addr = -1; min_addr = 1024;
    while (nwin < 676 && cyc < 20000) begin
      acc = 1'b0;
      if (ram_en_b) begin
        last_addr = int'(ram_addr_b);
        if (last_addr < min_addr) min_addr = last_addr;
      end
      if (done_b) ndone++;
      if (win_valid_b) begin
        er = nwin / (BW - K + 1);
        ec = nwin % (BW - K + 1);
        exp_d = model_win(mem_b, BBASE, BW, er, ec);
        vectors++;
        if (win_data_b !== exp_d || win_row_b !== 10'(er) || win_col_b !== 10'(ec)) begin
          miscompares++;
          $display("[TB] FAIL full_win%0d: got %h (%0d,%0d) want %h (%0d,%0d)",
                   nwin, win_data_b, win_row_b, win_col_b, exp_d, er, ec);
        end
        win_ready_b = ($urandom_range(0, 3) != 0);
        acc = win_ready_b;
      end else begin
        win_ready_b = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (acc) nwin++;
    end
    vectors++;
    if (nwin !== 676 || ndone !== 0 || done_b !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_count: got %0d windows early_done %0d done %b want 676 0 1", nwin, ndone, done_b);
    end
    vectors++;
    if (last_addr !== 883 || min_addr !== 100) begin
      miscompares++;
      $display("[TB] FAIL full_addr_range: got %0d..%0d want 100..883", min_addr, last_addr);
    end
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (done_b) ndone++;
    end
    vectors++;
    if (ndone !== 0 || busy_b !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_single_done: got %0d extra done busy %b want 0 0", ndone, busy_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_full_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
